// File: rtl/uart_rx_fifo.sv
// UART receiver (start/data MSB-first/parity/stop) feeding a first-word-fall-through FIFO.
// Define UART_RX_BREAK_DET_EN to build break detection; otherwise Break_Det is tied low.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 2,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                        SysClk,
  input  logic                        Rst_n,
  input  logic                        Baud_Tick,
  input  logic                        Rx,
  input  logic                        Rd_En,
  input  logic                        Err_Clr,
  output logic [DATA_BITS-1:0]        Rx_Data,
  output logic                        Data_Rdy,
  output logic                        FIFO_Full,
  output logic [$clog2(FIFO_DEPTH):0] Fill_Level,
  output logic [2:0]                  Rx_Error,
  output logic                        Break_Det
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
  localparam logic             PAR_ODD   = (PARITY_MODE == 2);
  localparam logic [AW:0]      DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  // Input synchronizer and start-edge arming
  logic       rx_meta;
  logic       rx_sync;
  logic [1:0] sync_vld;
  logic       armed;
  logic       start_taken;

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_sync <= rx_meta;
    end
  end

  // A start is only taken after the line has been seen high with real (post-reset) data,
  // so a line held low through reset or a break never launches a frame.
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rx_sync)
        armed <= 1'b1;
      else if (start_taken)
        armed <= 1'b0;
    end
  end

  // Receive FSM
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     tick_cnt, tick_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic                 par_err_q, par_err_nxt;
  logic                 frm_err_q, frm_err_nxt;
  logic                 all_zero_q, all_zero_nxt;
  logic                 wr_q, wr_nxt;
  logic                 perr_q, perr_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 sample;
`ifdef UART_RX_BREAK_DET_EN
  logic                 brk_q, brk_nxt;
`endif

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      all_zero_q <= 1'b0;
      wr_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      shift_q    <= shift_nxt;
      par_err_q  <= par_err_nxt;
      frm_err_q  <= frm_err_nxt;
      all_zero_q <= all_zero_nxt;
      wr_q       <= wr_nxt;
      perr_q     <= perr_nxt;
      ferr_q     <= ferr_nxt;
`ifdef UART_RX_BREAK_DET_EN
      brk_q      <= brk_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shift_nxt    = shift_q;
    par_err_nxt  = par_err_q;
    frm_err_nxt  = frm_err_q;
    all_zero_nxt = all_zero_q;
    wr_nxt       = 1'b0;
    perr_nxt     = 1'b0;
    ferr_nxt     = 1'b0;
    start_taken  = 1'b0;
    sample       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_nxt      = 1'b0;
`endif

    if (Baud_Tick && state != S_IDLE && state != S_BRK_WAIT) begin
      if (tick_cnt == ((state == S_START) ? HALF_M1 : FULL_M1)) begin
        sample       = 1'b1;
        tick_cnt_nxt = '0;
      end else begin
        tick_cnt_nxt = tick_cnt + 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        tick_cnt_nxt = '0;
        if (armed && !rx_sync) begin
          state_nxt   = S_START;
          start_taken = 1'b1;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_sync) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt    = S_DATA;
            bit_cnt_nxt  = '0;
            par_err_nxt  = 1'b0;
            frm_err_nxt  = 1'b0;
            all_zero_nxt = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_nxt    = {shift_q[DATA_BITS-2:0], rx_sync};
          all_zero_nxt = all_zero_q & ~rx_sync;
          if (bit_cnt == LAST_BIT) begin
            state_nxt    = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
            stop_cnt_nxt = 1'b0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_err_nxt  = ((^shift_q) ^ rx_sync) != PAR_ODD;
          all_zero_nxt = all_zero_q & ~rx_sync;
          state_nxt    = S_STOP;
          stop_cnt_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (sample) begin
          frm_err_nxt  = frm_err_q | ~rx_sync;
          all_zero_nxt = all_zero_q & ~rx_sync;
          if (stop_cnt == LAST_STOP) begin
            state_nxt = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
            if (all_zero_nxt) begin
              state_nxt = S_BRK_WAIT;
              brk_nxt   = 1'b1;
            end else begin
              perr_nxt = par_err_q;
              ferr_nxt = frm_err_nxt;
              wr_nxt   = ~par_err_q & ~frm_err_nxt;
            end
`else
            perr_nxt = par_err_q;
            ferr_nxt = frm_err_nxt;
            wr_nxt   = ~par_err_q & ~frm_err_nxt;
`endif
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      S_BRK_WAIT: begin
        if (rx_sync)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Receive FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, do_rd, do_wr, ovr;

  assign full  = (count == DEPTH_L);
  assign do_rd = Rd_En && (count != '0);
  assign do_wr = wr_q && (!full || do_rd);
  assign ovr   = wr_q && full && !Rd_En;

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge SysClk) begin
    if (do_wr)
      mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n)
      Rx_Error <= '0;
    else
      Rx_Error <= (Err_Clr ? 3'b000 : Rx_Error) | {ovr, ferr_q, perr_q};
  end

  assign Data_Rdy   = (count != '0);
  assign Rx_Data    = Data_Rdy ? mem[rd_ptr] : '0;
  assign FIFO_Full  = full;
  assign Fill_Level = count;

`ifdef UART_RX_BREAK_DET_EN
  assign Break_Det = brk_q;
`else
  assign Break_Det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected words and status checks,
// a negedge monitor compares them against the DUT.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

  localparam int K_FILL = 0;
  localparam int K_RDY  = 1;
  localparam int K_FULL = 2;
  localparam int K_ERR  = 3;
  localparam int K_DATA = 4;
  localparam int K_BDET = 5;
  localparam int K_BCNT = 6;
  localparam int K_SB   = 7;

  typedef struct {
    string name;
    int    kind;
    int    exp;
  } stat_t;

  logic       SysClk = 1'b0;
  logic       Rst_n;
  logic       Baud_Tick;
  logic       Rx;
  logic       Rd_En;
  logic       Err_Clr;
  logic [7:0] Rx_Data;
  logic       Data_Rdy;
  logic       FIFO_Full;
  logic [3:0] Fill_Level;
  logic [2:0] Rx_Error;
  logic       Break_Det;

  int         checks  = 0;
  int         errors  = 0;
  int         brk_cnt = 0;
  logic [7:0] exp_q[$];
  stat_t      st_q[$];

  uart_rx_fifo #(
    .DATA_BITS  (8),
    .STOP_BITS  (2),
    .PARITY_MODE(1),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (8)
  ) dut (
    .SysClk    (SysClk),
    .Rst_n     (Rst_n),
    .Baud_Tick (Baud_Tick),
    .Rx        (Rx),
    .Rd_En     (Rd_En),
    .Err_Clr   (Err_Clr),
    .Rx_Data   (Rx_Data),
    .Data_Rdy  (Data_Rdy),
    .FIFO_Full (FIFO_Full),
    .Fill_Level(Fill_Level),
    .Rx_Error  (Rx_Error),
    .Break_Det (Break_Det)
  );

  always #5 SysClk = ~SysClk;

  initial begin
    Baud_Tick = 1'b0;
    forever begin
      repeat (3) @(posedge SysClk);
      #1 Baud_Tick = 1'b1;
      @(posedge SysClk);
      #1 Baud_Tick = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: pops a word on every accepted read and evaluates queued status checks
  initial begin : monitor
    stat_t      s;
    int         act;
    logic [7:0] e;
    forever begin
      @(negedge SysClk);
      if (Break_Det) brk_cnt++;
      if (Rd_En && Data_Rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_data: got %02h, expected no word", Rx_Data);
        end else begin
          e = exp_q.pop_front();
          if (Rx_Data !== e) begin
            errors++;
            $display("FAIL rd_data: got %02h, expected %02h", Rx_Data, e);
          end
        end
      end
      while (st_q.size() > 0) begin
        s = st_q.pop_front();
        case (s.kind)
          K_FILL:  act = int'(Fill_Level);
          K_RDY:   act = int'(Data_Rdy);
          K_FULL:  act = int'(FIFO_Full);
          K_ERR:   act = int'(Rx_Error);
          K_DATA:  act = int'(Rx_Data);
          K_BDET:  act = int'(Break_Det);
          K_BCNT:  act = brk_cnt;
          K_SB:    act = exp_q.size();
          default: act = -1;
        endcase
        checks++;
        if (act != s.exp) begin
          errors++;
          $display("FAIL %s: got %0d, expected %0d", s.name, act, s.exp);
        end
      end
    end
  end

  task automatic expect_st(input string name, input int kind, input int exp);
    stat_t s;
    s.name = name;
    s.kind = kind;
    s.exp  = exp;
    st_q.push_back(s);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge SysClk);
    #1;
  endtask

  task automatic drive_for(input logic b, input int n);
    Rx = b;
    wait_clks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bad);
    drive_for(1'b0, BIT_CLKS);
    for (int i = 7; i >= 0; i--) drive_for(d[i], BIT_CLKS);
    drive_for((^d) ^ par_flip, BIT_CLKS);
    drive_for(~stop_bad, BIT_CLKS);
    drive_for(1'b1, BIT_CLKS + 8);
  endtask

  task automatic read_word();
    Rd_En = 1'b1;
    wait_clks(1);
    Rd_En = 1'b0;
    wait_clks(1);
  endtask

  task automatic pulse_clr();
    Err_Clr = 1'b1;
    wait_clks(1);
    Err_Clr = 1'b0;
    wait_clks(1);
  endtask

  initial begin : stimulus
    logic [7:0] b;
    Rst_n   = 1'b0;
    Rx      = 1'b1;
    Rd_En   = 1'b0;
    Err_Clr = 1'b0;
    wait_clks(3);
    expect_st("reset_fill", K_FILL, 0);
    expect_st("reset_rdy",  K_RDY,  0);
    expect_st("reset_full", K_FULL, 0);
    expect_st("reset_err",  K_ERR,  0);
    expect_st("reset_data", K_DATA, 0);
    expect_st("reset_brk",  K_BDET, 0);
    wait_clks(2);
    Rst_n = 1'b1;
    wait_clks(8);

    // single good frame, even parity bit 0
    send_frame(8'hA5, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    expect_st("a5_rdy",  K_RDY,  1);
    expect_st("a5_err",  K_ERR,  0);
    expect_st("a5_fill", K_FILL, 1);
    expect_st("a5_head", K_DATA, 8'hA5);
    wait_clks(1);
    read_word();
    expect_st("a5_empty", K_RDY, 0);
    wait_clks(1);

    // fill to capacity, then overrun
    for (int i = 0; i < 8; i++) begin
      b = 8'(i);
      send_frame(b, 1'b0, 1'b0);
      exp_q.push_back(b);
    end
    expect_st("full_flag", K_FULL, 1);
    expect_st("full_fill", K_FILL, 8);
    wait_clks(1);
    send_frame(8'h08, 1'b0, 1'b0);
    expect_st("ovr_err",  K_ERR,  4);
    expect_st("ovr_fill", K_FILL, 8);
    wait_clks(1);
    pulse_clr();
    expect_st("ovr_clr", K_ERR, 0);
    wait_clks(1);
    for (int i = 0; i < 8; i++) read_word();
    expect_st("drain_fill", K_FILL, 0);
    expect_st("drain_rdy",  K_RDY,  0);
    wait_clks(1);
    read_word();
    read_word();
    expect_st("empty_rd_fill", K_FILL, 0);
    expect_st("empty_rd_full", K_FULL, 0);
    wait_clks(1);

    // parity error
    send_frame(8'h3C, 1'b1, 1'b0);
    expect_st("par_err",  K_ERR,  1);
    expect_st("par_fill", K_FILL, 0);
    wait_clks(1);
    pulse_clr();
    expect_st("par_clr", K_ERR, 0);
    wait_clks(1);

    // framing error on first stop bit
    send_frame(8'h55, 1'b0, 1'b1);
    expect_st("frm_err",  K_ERR,  2);
    expect_st("frm_fill", K_FILL, 0);
    wait_clks(1);
    pulse_clr();
    expect_st("frm_clr", K_ERR, 0);
    wait_clks(1);

    // short low glitch rejected, next frame still received
    drive_for(1'b0, 16);
    drive_for(1'b1, 2 * BIT_CLKS);
    expect_st("glitch_fill", K_FILL, 0);
    expect_st("glitch_err",  K_ERR,  0);
    wait_clks(1);
    send_frame(8'h5A, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    expect_st("post_glitch_fill", K_FILL, 1);
    wait_clks(1);
    read_word();

    // line held low for 20 bit times
    drive_for(1'b0, 20 * BIT_CLKS);
    drive_for(1'b1, 2 * BIT_CLKS);
`ifdef UART_RX_BREAK_DET_EN
    expect_st("brk_pulses", K_BCNT, 1);
    expect_st("brk_err",    K_ERR,  0);
`else
    expect_st("brk_pulses", K_BCNT, 0);
    expect_st("brk_err",    K_ERR,  2);
`endif
    expect_st("brk_fill", K_FILL, 0);
    wait_clks(1);
    pulse_clr();

    // reset mid-frame empties the FIFO and waits for a fresh start edge
    send_frame(8'h11, 1'b0, 1'b0);
    exp_q.push_back(8'h11);
    expect_st("pre_rst_fill", K_FILL, 1);
    wait_clks(1);
    drive_for(1'b0, 4 * BIT_CLKS);
    Rst_n = 1'b0;
    wait_clks(2);
    exp_q.delete();
    expect_st("midrst_fill", K_FILL, 0);
    expect_st("midrst_rdy",  K_RDY,  0);
    expect_st("midrst_data", K_DATA, 0);
    wait_clks(2);
    Rst_n = 1'b1;
    drive_for(1'b0, 3 * BIT_CLKS);
    drive_for(1'b1, 3 * BIT_CLKS);
    expect_st("post_rst_fill", K_FILL, 0);
    expect_st("post_rst_err",  K_ERR,  0);
    wait_clks(1);
    send_frame(8'h96, 1'b0, 1'b0);
    exp_q.push_back(8'h96);
    expect_st("recover_fill", K_FILL, 1);
    wait_clks(1);
    read_word();

    expect_st("sb_left", K_SB, 0);
    wait_clks(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
